r5p_tcb_trace: RTL and testbench
================================

Name: r5p_tcb_trace

Overview:
- Synthesizable retirement-trace collector for R5P cores; passively taps the IFU and LSU TCB busses and the GPR write port, never drives them.
- Each trace record combines one retired instruction with its fetch address and encoding, its GPR write-back, and its memory access, if any.
- Records leave through a valid/ready stream from a parametrised output FIFO, which feeds a trace DMA or debug port.
- Generalised in data width, TCB response delay and buffer depth; adds statistics counters and overflow accounting.

Parameters:
- XLEN, 32, data/address width.
- GNUM, 32, number of GPRs; GLOG = $clog2(GNUM) is derived.
- DLY, 1, TCB response delay in clock cycles (≥1); applies to both busses.
- DEPTH, 8, output record FIFO depth (power of 2, ≥2).
- CW, 32, width of the statistics counters and sequence number.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- trc_en  in  1  tracing enable.
- ifu_vld, ifu_rdy  in  1  IFU TCB handshake.
- ifu_adr  in  XLEN  IFU request address.
- ifu_rdt  in  XLEN  IFU response data.
- lsu_vld, lsu_rdy, lsu_wen  in  1  LSU handshake and write enable.
- lsu_adr, lsu_wdt, lsu_rdt  in  XLEN  LSU address, write data, read data.
- gpr_wen  in  1  GPR write enable.
- gpr_wid  in  GLOG  GPR write index.
- gpr_wdt  in  XLEN  GPR write data.
- trc_vld  out  1  record valid.
- trc_rdy  in  1  record accepted.
- trc_dat  out  trace_rec_t  record: seq, pc, ins, siz, gpr_wen, gpr_wid, gpr_wdt, lsu_vld, lsu_wen, lsu_adr, lsu_dat, lsu_err.
- ovf  out  1  sticky overflow flag.
- cnt_ret, cnt_ld, cnt_st, cnt_drop  out  CW  counts of retired instructions, loads, stores and dropped records.

Behaviour:
- A transfer occurs when vld&rdy. Request fields are delayed by a DLY-stage shift register. Response data is sampled in the cycle where the delayed transfer flag is 1 (fetch event / LSU event).
- LSU event:
  - Latched into a window register: lsu_vld=1, wen, adr, dat = wdt if wen else rdt.
  - A second LSU event in the same window overwrites the register and sets lsu_err=1.
- Fetch event k at cycle t:
  - If a pending fetch exists, a record is formed from the pending fetch (k-1), the window register, and the GPR port sampled at t. gpr_wen=0 when gpr_wid==0.
  - The pending register then loads fetch k, and the window clears. If an LSU event occurs in the same cycle t, it belongs to the new window.
- The first fetch after reset only loads the pending register; no record is produced.
- siz = 4 if ifu_rdt[1:0]==2'b11, else 2. For siz==2, ins upper 16 bits are zero.
- seq increments per formed record, including dropped ones, wrapping modulo 2^CW.
- Record push:
  - Push to the FIFO if trc_en=1 and the FIFO is not full.
  - If the FIFO is full (pop in the same cycle frees no space for that push), the record is dropped: cnt_drop increments and ovf is set.
  - trc_en=0: no push and no drop counted, but seq and the counters still advance.
- FIFO behaviour:
  - First-word fall-through; trc_vld = !empty; pop on trc_vld&trc_rdy.
  - Simultaneous push and pop when full is a drop; when empty, it is a normal push.
- ovf clears only on reset.
- Counters:
  - cnt_ret +1 per formed record.
  - cnt_ld / cnt_st +1 per record whose lsu_vld=1 with wen 0 / 1.
  - All counters saturate at 2^CW-1; seq wraps.
- Reset values: all outputs 0 (trc_vld=0, ovf=0, counters 0). FIFO pointers and pending/window valid bits are 0. Data fields are don't-care.
- Reset mid-operation discards the pending fetch, the window and the FIFO contents. Trace restarts with seq=0.
- Latency: a record is visible on trc_vld one cycle after the fetch event that closes it.

Decomposition:
- Package r5p_trace_pkg holds:
  - trace_rec_t (packed struct, parametrised via XLEN/GLOG package constants);
  - the siz decode function;
  - the saturating-increment function.
- One natural sub-module, r5p_trace_fifo: a generic FWFT FIFO with full/empty flags, instantiated for the record queue.

Test Plan:
- DLY=1, fetches at pc 0x0, 0x4, 0x8. Instruction at 0x0 is addi (0x00500093) with x1 written 0x5 at the second fetch event → first record seq=0, pc=0x0, ins=0x00500093, siz=4, gpr_wid=1, gpr_wdt=0x5, lsu_vld=0; cnt_ret=2 after the third fetch.
- Compressed instruction 0x4501 at pc 0x100 → record siz=2, ins=0x00004501.
- Store of 0xDEADBEEF to 0x2000 in window 2, then load from 0x2000 returning 0xDEADBEEF in window 3 → records show lsu_wen=1 and 0, lsu_dat=0xDEADBEEF; cnt_st=1, cnt_ld=1.
- Two LSU transfers within one window → lsu_err=1, second access recorded.
- DEPTH=8, trc_rdy=0, 12 records formed → 8 buffered (seq 0-7), cnt_drop=4, ovf=1. Then trc_rdy=1 drains seq 0..7 in order; the next record arrives with seq=12.
- Reset asserted with 3 records queued → trc_vld=0 and counters 0 immediately (asynchronous). After release, the first record has seq=0; DLY=3 run repeats the first scenario with identical records.

Source files
------------

// File: rtl/r5p_trace_pkg.sv
// Shared types and helpers for the R5P retirement-trace collector.
// The record layout is fixed by the package constants below.
package r5p_trace_pkg;

    localparam int XLEN = 32;
    localparam int GNUM = 32;
    localparam int GLOG = $clog2(GNUM);
    localparam int CW   = 32;

    typedef struct packed {
        logic [CW-1:0]   seq;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] ins;
        logic [2:0]      siz;
        logic            gpr_wen;
        logic [GLOG-1:0] gpr_wid;
        logic [XLEN-1:0] gpr_wdt;
        logic            lsu_vld;
        logic            lsu_wen;
        logic [XLEN-1:0] lsu_adr;
        logic [XLEN-1:0] lsu_dat;
        logic            lsu_err;
    } trace_rec_t;

    // Instruction size in bytes from the two opcode LSBs (11 = 32-bit, else compressed)
    function automatic logic [2:0] siz_dec(input logic [1:0] op);
        return (op == 2'b11) ? 3'd4 : 3'd2;
    endfunction

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] val);
        return (val == {CW{1'b1}}) ? val : val + 1'b1;
    endfunction

endpackage

// File: rtl/r5p_trace_fifo.sv
// Generic first-word-fall-through FIFO with full/empty flags.
// Pushes while full and pops while empty are ignored.
module r5p_trace_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] wdat,
    input  logic          pop,
    output logic [DW-1:0] rdat,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdat  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= wdat;
    end

endmodule

// File: rtl/r5p_tcb_trace.sv
// Passive retirement-trace collector: taps IFU/LSU TCB busses and the GPR write
// port, pairs each fetch with its write-back and memory access, streams records out.
module r5p_tcb_trace #(
    parameter int XLEN  = 32,
    parameter int GNUM  = 32,
    parameter int DLY   = 1,
    parameter int DEPTH = 8,
    parameter int CW    = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          trc_en,
    input  logic                          ifu_vld,
    input  logic                          ifu_rdy,
    input  logic [XLEN-1:0]               ifu_adr,
    input  logic [XLEN-1:0]               ifu_rdt,
    input  logic                          lsu_vld,
    input  logic                          lsu_rdy,
    input  logic                          lsu_wen,
    input  logic [XLEN-1:0]               lsu_adr,
    input  logic [XLEN-1:0]               lsu_wdt,
    input  logic [XLEN-1:0]               lsu_rdt,
    input  logic                          gpr_wen,
    input  logic [$clog2(GNUM)-1:0]       gpr_wid,
    input  logic [XLEN-1:0]               gpr_wdt,
    output logic                          trc_vld,
    input  logic                          trc_rdy,
    output r5p_trace_pkg::trace_rec_t     trc_dat,
    output logic                          ovf,
    output logic [CW-1:0]                 cnt_ret,
    output logic [CW-1:0]                 cnt_ld,
    output logic [CW-1:0]                 cnt_st,
    output logic [CW-1:0]                 cnt_drop
);

    import r5p_trace_pkg::*;

    // request-side delay lines, aligning each request with its response cycle
    logic [DLY-1:0]  ifu_dv;
    logic [XLEN-1:0] ifu_da [DLY];
    logic [DLY-1:0]  lsu_dv;
    logic [DLY-1:0]  lsu_dw;
    logic [XLEN-1:0] lsu_da [DLY];
    logic [XLEN-1:0] lsu_dd [DLY];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ifu_dv <= '0;
            lsu_dv <= '0;
        end else begin
            ifu_dv[0] <= ifu_vld & ifu_rdy;
            lsu_dv[0] <= lsu_vld & lsu_rdy;
            for (int i = 1; i < DLY; i++) begin
                ifu_dv[i] <= ifu_dv[i-1];
                lsu_dv[i] <= lsu_dv[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        ifu_da[0] <= ifu_adr;
        lsu_dw[0] <= lsu_wen;
        lsu_da[0] <= lsu_adr;
        lsu_dd[0] <= lsu_wdt;
        for (int i = 1; i < DLY; i++) begin
            ifu_da[i] <= ifu_da[i-1];
            lsu_dw[i] <= lsu_dw[i-1];
            lsu_da[i] <= lsu_da[i-1];
            lsu_dd[i] <= lsu_dd[i-1];
        end
    end

    logic            fetch_ev;
    logic            lsu_ev;
    logic [XLEN-1:0] lsu_dat_ev;
    logic [2:0]      fetch_siz;

    assign fetch_ev   = ifu_dv[DLY-1];
    assign lsu_ev     = lsu_dv[DLY-1];
    assign lsu_dat_ev = lsu_dw[DLY-1] ? lsu_dd[DLY-1] : lsu_rdt;
    assign fetch_siz  = siz_dec(ifu_rdt[1:0]);

    // pending fetch (awaiting its retirement) and the LSU window that belongs to it
    logic            pend_vld;
    logic [XLEN-1:0] pend_pc;
    logic [XLEN-1:0] pend_ins;
    logic [2:0]      pend_siz;
    logic            win_vld;
    logic            win_wen;
    logic [XLEN-1:0] win_adr;
    logic [XLEN-1:0] win_dat;
    logic            win_err;
    logic [CW-1:0]   seq;

    trace_rec_t rec;
    logic       rec_form;
    logic       fifo_full;
    logic       fifo_empty;
    logic       rec_push;
    logic       rec_drop;

    always_comb begin
        rec         = '0;
        rec.seq     = seq;
        rec.pc      = pend_pc;
        rec.ins     = pend_ins;
        rec.siz     = pend_siz;
        rec.gpr_wen = gpr_wen && (gpr_wid != '0);
        rec.gpr_wid = gpr_wid;
        rec.gpr_wdt = gpr_wdt;
        rec.lsu_vld = win_vld;
        rec.lsu_wen = win_vld & win_wen;
        rec.lsu_adr = win_vld ? win_adr : '0;
        rec.lsu_dat = win_vld ? win_dat : '0;
        rec.lsu_err = win_vld & win_err;
    end

    assign rec_form = fetch_ev && pend_vld;
    assign rec_push = rec_form && trc_en && !fifo_full;
    assign rec_drop = rec_form && trc_en && fifo_full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_vld <= 1'b0;
            pend_pc  <= '0;
            pend_ins <= '0;
            pend_siz <= '0;
            win_vld  <= 1'b0;
            win_wen  <= 1'b0;
            win_adr  <= '0;
            win_dat  <= '0;
            win_err  <= 1'b0;
            seq      <= '0;
            cnt_ret  <= '0;
            cnt_ld   <= '0;
            cnt_st   <= '0;
            cnt_drop <= '0;
            ovf      <= 1'b0;
        end else begin
            if (fetch_ev) begin
                pend_vld <= 1'b1;
                pend_pc  <= ifu_da[DLY-1];
                pend_siz <= fetch_siz;
                pend_ins <= (fetch_siz == 3'd4) ? ifu_rdt : {{(XLEN-16){1'b0}}, ifu_rdt[15:0]};
            end
            // an LSU event coinciding with a fetch event opens the new window
            if (lsu_ev) begin
                win_vld <= 1'b1;
                win_wen <= lsu_dw[DLY-1];
                win_adr <= lsu_da[DLY-1];
                win_dat <= lsu_dat_ev;
                win_err <= win_vld && !fetch_ev;
            end else if (fetch_ev) begin
                win_vld <= 1'b0;
                win_err <= 1'b0;
            end
            if (rec_form) begin
                seq     <= seq + 1'b1;
                cnt_ret <= sat_inc(cnt_ret);
                if (win_vld && !win_wen)
                    cnt_ld <= sat_inc(cnt_ld);
                if (win_vld && win_wen)
                    cnt_st <= sat_inc(cnt_st);
            end
            if (rec_drop) begin
                cnt_drop <= sat_inc(cnt_drop);
                ovf      <= 1'b1;
            end
        end
    end

    r5p_trace_fifo #(
        .DW    ($bits(trace_rec_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rec_push),
        .wdat  (rec),
        .pop   (trc_rdy),
        .rdat  (trc_dat),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign trc_vld = !fifo_empty;

endmodule

// File: tb/tb_r5p_tcb_trace.sv
// Bench for r5p_tcb_trace: one event schedule drives a DLY=1 and a DLY=3 instance,
// both compared each cycle against a queue-based record model.
module tb_r5p_tcb_trace;
    import r5p_trace_pkg::*;

    localparam int NEV   = 4096;
    localparam int DEPTH = 8;

    typedef struct {
        bit          f_v;
        logic [31:0] f_adr;
        logic [31:0] f_rdt;
        bit          l_v;
        logic        l_wen;
        logic [31:0] l_adr;
        logic [31:0] l_wdt;
        logic [31:0] l_rdt;
        logic        g_wen;
        logic [4:0]  g_wid;
        logic [31:0] g_wdt;
    } ev_t;

    typedef struct packed {
        logic        wen;
        logic [31:0] adr;
        logic [31:0] dat;
    } lsu_t;

    ev_t ev    [NEV];
    bit  rdy_a [NEV];
    bit  en_a  [NEV];

    logic        clk = 1'b0;
    logic        rst;
    logic        trc_en, trc_rdy;
    logic [31:0] ifu_rdt, lsu_rdt, gpr_wdt;
    logic        gpr_wen;
    logic [4:0]  gpr_wid;
    logic        ifu_vld1, ifu_rdy1, lsu_vld1, lsu_rdy1, lsu_wen1;
    logic [31:0] ifu_adr1, lsu_adr1, lsu_wdt1;
    logic        ifu_vld3, ifu_rdy3, lsu_vld3, lsu_rdy3, lsu_wen3;
    logic [31:0] ifu_adr3, lsu_adr3, lsu_wdt3;
    logic        trc_vld1, trc_vld3, ovf1, ovf3;
    trace_rec_t  trc_dat1, trc_dat3;
    logic [31:0] cnt_ret1, cnt_ld1, cnt_st1, cnt_drop1;
    logic [31:0] cnt_ret3, cnt_ld3, cnt_st3, cnt_drop3;

    always #5 clk = ~clk;

    r5p_tcb_trace #(.DLY(1), .DEPTH(DEPTH)) dut1 (
        .clk(clk), .rst(rst), .trc_en(trc_en),
        .ifu_vld(ifu_vld1), .ifu_rdy(ifu_rdy1), .ifu_adr(ifu_adr1), .ifu_rdt(ifu_rdt),
        .lsu_vld(lsu_vld1), .lsu_rdy(lsu_rdy1), .lsu_wen(lsu_wen1),
        .lsu_adr(lsu_adr1), .lsu_wdt(lsu_wdt1), .lsu_rdt(lsu_rdt),
        .gpr_wen(gpr_wen), .gpr_wid(gpr_wid), .gpr_wdt(gpr_wdt),
        .trc_vld(trc_vld1), .trc_rdy(trc_rdy), .trc_dat(trc_dat1), .ovf(ovf1),
        .cnt_ret(cnt_ret1), .cnt_ld(cnt_ld1), .cnt_st(cnt_st1), .cnt_drop(cnt_drop1)
    );

    r5p_tcb_trace #(.DLY(3), .DEPTH(DEPTH)) dut3 (
        .clk(clk), .rst(rst), .trc_en(trc_en),
        .ifu_vld(ifu_vld3), .ifu_rdy(ifu_rdy3), .ifu_adr(ifu_adr3), .ifu_rdt(ifu_rdt),
        .lsu_vld(lsu_vld3), .lsu_rdy(lsu_rdy3), .lsu_wen(lsu_wen3),
        .lsu_adr(lsu_adr3), .lsu_wdt(lsu_wdt3), .lsu_rdt(lsu_rdt),
        .gpr_wen(gpr_wen), .gpr_wid(gpr_wid), .gpr_wdt(gpr_wdt),
        .trc_vld(trc_vld3), .trc_rdy(trc_rdy), .trc_dat(trc_dat3), .ovf(ovf3),
        .cnt_ret(cnt_ret3), .cnt_ld(cnt_ld3), .cnt_st(cnt_st3), .cnt_drop(cnt_drop3)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    // reference model state
    bit          m_pend;
    logic [31:0] m_pc, m_rdt;
    lsu_t        wq [$];
    trace_rec_t  mq [$];
    logic [31:0] m_seq;
    int unsigned m_ret, m_ld, m_st, m_drop;
    logic        m_ovf;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_pend = 0; wq.delete(); mq.delete();
        m_seq = '0; m_ret = 0; m_ld = 0; m_st = 0; m_drop = 0; m_ovf = 0;
    endfunction

    function automatic void sch_fetch(input int c, input logic [31:0] adr, input logic [31:0] rdt);
        ev[c].f_v = 1; ev[c].f_adr = adr; ev[c].f_rdt = rdt;
    endfunction

    function automatic void sch_lsu(input int c, input logic wen, input logic [31:0] adr,
                                    input logic [31:0] wdt, input logic [31:0] rdt);
        ev[c].l_v = 1; ev[c].l_wen = wen; ev[c].l_adr = adr; ev[c].l_wdt = wdt; ev[c].l_rdt = rdt;
    endfunction

    function automatic void sch_gpr(input int c, input logic wen, input logic [4:0] wid, input logic [31:0] wdt);
        ev[c].g_wen = wen; ev[c].g_wid = wid; ev[c].g_wdt = wdt;
    endfunction

    function automatic void set_rdy(input int a, input int b, input bit v);
        for (int c = a; c < b; c++) rdy_a[c] = v;
    endfunction

    task automatic drive(input int c);
        ev_t e0, e1, e3;
        int  r;
        e0 = ev[c]; e1 = ev[c+1]; e3 = ev[c+3];
        trc_en  = en_a[c];
        trc_rdy = rdy_a[c];
        ifu_rdt = e0.f_rdt; lsu_rdt = e0.l_rdt;
        gpr_wen = e0.g_wen; gpr_wid = e0.g_wid; gpr_wdt = e0.g_wdt;
        // a request is issued DLY cycles before its event; idle cycles carry non-transfer noise
        r = $urandom_range(0, 2);
        ifu_vld1 = e1.f_v | (r == 1); ifu_rdy1 = e1.f_v | (r == 2); ifu_adr1 = e1.f_adr;
        r = $urandom_range(0, 2);
        ifu_vld3 = e3.f_v | (r == 1); ifu_rdy3 = e3.f_v | (r == 2); ifu_adr3 = e3.f_adr;
        r = $urandom_range(0, 2);
        lsu_vld1 = e1.l_v | (r == 1); lsu_rdy1 = e1.l_v | (r == 2);
        lsu_wen1 = e1.l_wen; lsu_adr1 = e1.l_adr; lsu_wdt1 = e1.l_wdt;
        r = $urandom_range(0, 2);
        lsu_vld3 = e3.l_v | (r == 1); lsu_rdy3 = e3.l_v | (r == 2);
        lsu_wen3 = e3.l_wen; lsu_adr3 = e3.l_adr; lsu_wdt3 = e3.l_wdt;
    endtask

    task automatic model(input int c);
        ev_t        e;
        trace_rec_t r;
        lsu_t       w;
        bit         formed, pushf, pop;
        e = ev[c]; formed = 0; pushf = 0; r = '0;
        pop = (mq.size() != 0) && rdy_a[c];
        if (e.f_v) begin
            if (m_pend) begin
                r.seq = m_seq;
                r.pc  = m_pc;
                if (m_rdt[1:0] == 2'b11) begin r.siz = 3'd4; r.ins = m_rdt; end
                else begin r.siz = 3'd2; r.ins = {16'h0, m_rdt[15:0]}; end
                r.gpr_wen = e.g_wen && (e.g_wid != 5'd0);
                r.gpr_wid = e.g_wid;
                r.gpr_wdt = e.g_wdt;
                if (wq.size() != 0) begin
                    w = wq[$];
                    r.lsu_vld = 1; r.lsu_wen = w.wen; r.lsu_adr = w.adr; r.lsu_dat = w.dat;
                    r.lsu_err = (wq.size() > 1);
                end
                formed = 1;
            end
            m_pend = 1; m_pc = e.f_adr; m_rdt = e.f_rdt;
            wq.delete();
        end
        if (e.l_v) begin
            w.wen = e.l_wen; w.adr = e.l_adr; w.dat = e.l_wen ? e.l_wdt : e.l_rdt;
            wq.push_back(w);
        end
        if (formed) begin
            m_seq++; m_ret++;
            if (r.lsu_vld && r.lsu_wen) m_st++;
            if (r.lsu_vld && !r.lsu_wen) m_ld++;
            if (en_a[c]) begin
                if (mq.size() >= DEPTH) begin m_drop++; m_ovf = 1; end
                else pushf = 1;
            end
        end
        if (pop) void'(mq.pop_front());
        if (pushf) mq.push_back(r);
    endtask

    task automatic chk_out();
        chk("vld1", trc_vld1, mq.size() != 0);
        chk("vld3", trc_vld3, mq.size() != 0);
        if (mq.size() != 0) begin
            chk("dat1", trc_dat1, mq[0]);
            chk("dat3", trc_dat3, mq[0]);
        end
        chk("ret1", cnt_ret1, m_ret);   chk("ret3", cnt_ret3, m_ret);
        chk("ld1", cnt_ld1, m_ld);      chk("ld3", cnt_ld3, m_ld);
        chk("st1", cnt_st1, m_st);      chk("st3", cnt_st3, m_st);
        chk("drop1", cnt_drop1, m_drop); chk("drop3", cnt_drop3, m_drop);
        chk("ovf1", ovf1, m_ovf);       chk("ovf3", ovf3, m_ovf);
    endtask

    task automatic step();
        chk_out();
        drive(cyc);
        if (rst) model(cyc);
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_to(input int c);
        while (cyc < c && cyc < NEV - 4) step();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_vld1"}, trc_vld1, 1'b0);  chk({tag, "_vld3"}, trc_vld3, 1'b0);
        chk({tag, "_ret1"}, cnt_ret1, 0);     chk({tag, "_ret3"}, cnt_ret3, 0);
        chk({tag, "_ld1"}, cnt_ld1, 0);       chk({tag, "_st1"}, cnt_st1, 0);
        chk({tag, "_drop1"}, cnt_drop1, 0);   chk({tag, "_drop3"}, cnt_drop3, 0);
        chk({tag, "_ovf1"}, ovf1, 1'b0);      chk({tag, "_ovf3"}, ovf3, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk_zero("rst");
        model_reset();
        repeat (3) step();
        rst = 1'b1;
    endtask

    // fetches at 0x0/0x4/0x8; addi at 0x0 retires writing x1=5
    task automatic scen1();
        int c0;
        c0 = cyc + 4;
        set_rdy(cyc, c0 + 6, 0);
        sch_fetch(c0, 32'h0, 32'h0050_0093);
        sch_fetch(c0 + 2, 32'h4, 32'h0010_8113);
        sch_gpr(c0 + 2, 1'b1, 5'd1, 32'h5);
        sch_fetch(c0 + 4, 32'h8, 32'h0000_0013);
        run_to(c0 + 6);
        chk("s1_ret1", cnt_ret1, 2);            chk("s1_ret3", cnt_ret3, 2);
        chk("s1_seq1", trc_dat1.seq, 0);        chk("s1_seq3", trc_dat3.seq, 0);
        chk("s1_pc1", trc_dat1.pc, 0);          chk("s1_ins1", trc_dat1.ins, 32'h0050_0093);
        chk("s1_siz1", trc_dat1.siz, 4);        chk("s1_gwen1", trc_dat1.gpr_wen, 1'b1);
        chk("s1_gwid1", trc_dat1.gpr_wid, 1);   chk("s1_gwdt1", trc_dat1.gpr_wdt, 5);
        chk("s1_lvld1", trc_dat1.lsu_vld, 1'b0);
        chk("s1_ins3", trc_dat3.ins, 32'h0050_0093);
        chk("s1_gwdt3", trc_dat3.gpr_wdt, 5);
    endtask

    initial begin
        int c, gap, mode;
        for (int i = 0; i < NEV; i++) begin
            ev[i].f_v = 0; ev[i].f_adr = $urandom; ev[i].f_rdt = $urandom;
            ev[i].l_v = 0; ev[i].l_wen = 1'($urandom_range(0, 1));
            ev[i].l_adr = $urandom; ev[i].l_wdt = $urandom; ev[i].l_rdt = $urandom;
            ev[i].g_wen = 1'($urandom_range(0, 1)); ev[i].g_wid = 5'($urandom_range(0, 31));
            ev[i].g_wdt = $urandom;
            rdy_a[i] = 1; en_a[i] = 1;
        end

        rst = 1'b0;
        model_reset();
        drive(0);
        repeat (2) @(negedge clk);
        chk_zero("init");
        rst = 1'b1;

        scen1();

        // compressed fetch, store, load, and a window with two accesses
        c = cyc + 4;
        sch_fetch(c, 32'h100, 32'hABCD_4501);
        sch_fetch(c + 2, 32'h102, 32'h00A0_2023);
        sch_lsu(c + 3, 1'b1, 32'h2000, 32'hDEAD_BEEF, $urandom);
        sch_fetch(c + 5, 32'h106, 32'h0000_2083);
        sch_lsu(c + 5, 1'b0, 32'h2000, $urandom, 32'hDEAD_BEEF);
        sch_fetch(c + 8, 32'h10A, 32'h0000_2103);
        sch_lsu(c + 9, 1'b0, 32'h3000, $urandom, 32'h1111_1111);
        sch_lsu(c + 10, 1'b1, 32'h3004, 32'h2222_2222, $urandom);
        sch_fetch(c + 12, 32'h10E, 32'h0000_0001);
        sch_fetch(c + 14, 32'h110, 32'h0000_0013);
        run_to(c + 16);
        chk("c_st1", cnt_st1, 2); chk("c_ld1", cnt_ld1, 1);
        chk("c_st3", cnt_st3, 2); chk("c_ld3", cnt_ld3, 1);

        // randomized traffic with alternating light/heavy back-pressure
        c = cyc + 4;
        mode = 0;
        for (int k = 0; k < 300; k++) begin
            if (k % 50 == 0) mode = 1 - mode;
            gap = $urandom_range(1, 4);
            sch_fetch(c, $urandom, $urandom);
            for (int j = 0; j < gap; j++) begin
                if ($urandom_range(0, 2) == 0)
                    sch_lsu(c + j, 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom);
                rdy_a[c + j] = mode ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
                en_a[c + j]  = ($urandom_range(0, 9) != 0);
            end
            c += gap;
        end
        run_to(c + 20);

        // reset with three records queued
        c = cyc + 4;
        set_rdy(cyc, c + 6, 0);
        for (int i = 0; i < 4; i++) sch_fetch(c + i, 32'h500 + 32'(4 * i), 32'h0000_0013);
        run_to(c + 5);
        chk("pre_rst_vld1", trc_vld1, 1'b1);
        chk("pre_rst_vld3", trc_vld3, 1'b1);
        do_reset();

        // overflow: 12 records into an 8-deep queue with the sink stalled
        c = cyc + 4;
        set_rdy(cyc, c + 16, 0);
        for (int i = 0; i < 13; i++) sch_fetch(c + i, 32'h1000 + 32'(4 * i), $urandom);
        run_to(c + 15);
        chk("ovf_drop1", cnt_drop1, 4); chk("ovf_drop3", cnt_drop3, 4);
        chk("ovf_flag1", ovf1, 1'b1);   chk("ovf_flag3", ovf3, 1'b1);
        chk("ovf_ret1", cnt_ret1, 12);  chk("ovf_head1", trc_dat1.seq, 0);
        run_to(cyc + 12);
        c = cyc + 4;
        set_rdy(cyc, c + 3, 0);
        sch_fetch(c, 32'h2000, $urandom);
        run_to(c + 2);
        chk("next_vld1", trc_vld1, 1'b1);
        chk("next_seq1", trc_dat1.seq, 12);
        chk("next_seq3", trc_dat3.seq, 12);
        run_to(cyc + 4);

        do_reset();
        scen1();
        run_to(cyc + 10);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
